output_port_allocator: RTL and testbench
========================================

// Module: output_port_allocator
// PURPOSE
//  Per-output-port wormhole allocator for the 5-port NoC router. Arbitrates head-flit requests
//  from the five input ports round-robin, locks the winner onto this output until its tail flit
//  passes, and gates every flit transfer on a downstream credit counter. One instance per output;
//  drives the crossbar mux select and the input-buffer pop strobes.
// PARAMETERS
//  NPORTS     5  number of input ports requesting this output (index 0=LOCAL,1=N,2=E,3=S,4=W)
//  BUF_DEPTH  4  downstream input-buffer depth in flits = reset/maximum credit count
//  CW         $clog2(BUF_DEPTH+1)  credit counter width (derived, do not override)
// PORTS
//  clk           in   1       router clock
//  rst_n         in   1       asynchronous active-low reset
//  req_i         in   NPORTS  input i has a head flit routed to this output
//  flit_valid_i  in   NPORTS  input i presents a valid flit at its buffer head
//  flit_tail_i   in   NPORTS  flit presented by input i is a tail (head==tail legal)
//  credit_i      in   1       downstream freed one buffer slot (one pulse = one credit)
//  grant_o       out  NPORTS  one-hot current owner, registered; 0 when idle
//  sel_o         out  $clog2(NPORTS)  crossbar select = owner index; 0 when idle
//  xfer_o        out  NPORTS  one-hot: owner's flit moves this cycle (pop input, push crossbar)
//  busy_o        out  1       output locked to an owner
//  credits_o     out  CW      current credit count
//  credit_err_o  out  1       sticky: credit_i received while credits==BUF_DEPTH
// BEHAVIOUR
//  Reset: state=IDLE, pointer=0, grant_o=0, sel_o=0, xfer_o=0, busy_o=0, credits=BUF_DEPTH,
//   credit_err_o=0. Async assert, sync-clean deassert via normal flop behaviour.
//  FSM, 2 states:
//   IDLE:   if |req_i -> pick winner w: first set bit of req_i searching from pointer upward,
//           wrapping NPORTS-1 -> 0. Next cycle: LOCKED, owner=w, pointer=(w==NPORTS-1)?0:w+1.
//           No req -> stay IDLE, pointer unchanged. xfer_o=0 in IDLE.
//   LOCKED: xfer_o[owner]=flit_valid_i[owner] && credits!=0 (combinational from state/credits).
//           xfer with flit_tail_i[owner] -> IDLE next cycle, grant_o/busy_o drop next cycle.
//           req_i from any port, including owner, ignored while LOCKED; lock ends only on tail xfer.
//  Latency: req_i high in cycle T -> grant_o/busy_o/sel_o valid at T+1, earliest xfer at T+1.
//   Tail xfer at T -> IDLE at T+1 (re-arbitrate) -> next grant at T+2: one idle bubble per packet.
//  Credits: next = credits + credit_i - (|xfer_o). Simultaneous credit_i and xfer -> unchanged.
//   credits==0 -> xfer_o held 0, owner keeps lock (stall, no timeout).
//   credit_i at credits==BUF_DEPTH with no xfer -> count holds at BUF_DEPTH, credit_err_o set,
//   cleared only by reset. Never underflows (xfer requires credits!=0).
//  Fairness: a port that just won is lowest priority next arbitration; any continuously
//   requesting port is granted within NPORTS-1 other packets.
//  Reset mid-packet: lock and credits discarded, all outputs return to reset values immediately.
// STRUCTURE
//  noc_pkg: NPORTS constant, port_idx_e enum (LOCAL,NORTH,EAST,SOUTH,WEST), alloc_state_e {IDLE,LOCKED}.
//  Sub-module rr_priority_pick: combinational, inputs req[NPORTS] + pointer, outputs one-hot
//   win + win index + any; no state. Allocator holds pointer, owner, FSM, credit counter.
//  All outputs driven from registered state plus credits/flit_valid_i; no path req_i -> xfer_o.
// TESTING
//  1 Reset, req_i=5'b00100 one cycle -> grant_o=5'b00100, sel_o=2 next cycle; pointer=3.
//  2 Pointer=3, req_i=5'b10101 held -> packets granted in order 4,0,2,4 (wrap 4->0 verified).
//  3 Owner=1, 4-flit packet, flit_valid_i[1]=1 every cycle, other reqs high -> xfer_o[1] x4,
//    no grant change until tail xfer; single-flit packet (head=tail) releases after 1 xfer.
//  4 BUF_DEPTH=4, no credit_i, 6-flit packet -> 4 xfers, credits_o=0, stall; credit_i pulse ->
//    exactly 1 further xfer; credit_i+xfer same cycle -> credits_o unchanged.
//  5 Credit_i at credits_o=4 while idle -> credits_o stays 4, credit_err_o=1 and sticky.
//  6 rst_n low mid-packet (owner=3, credits=1) -> same cycle grant_o=0, busy_o=0,
//    credits_o=4; after release first grant searches from port 0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC router definitions used by the output-port allocator slice.
// NPORTS/BUF_DEPTH: default router geometry (5 ports, 4-flit input buffers).
// port_idx_e: input port numbering. alloc_state_e: allocator FSM states.
package noc_pkg;

    localparam int unsigned NPORTS    = 5;
    localparam int unsigned BUF_DEPTH = 4;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        EAST  = 3'd2,
        SOUTH = 3'd3,
        WEST  = 3'd4
    } port_idx_e;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_e;

endpackage

// File: rtl/output_port_allocator_if.sv
// Signal bundle between the input side / downstream credit return and one
// output-port allocator.
//   req_i, flit_valid_i, flit_tail_i  per-input request and flit status
//   credit_i                          one pulse per freed downstream slot
//   grant_o, sel_o, busy_o            current owner (one-hot / index / locked)
//   xfer_o                            one-hot flit move strobe
//   credits_o, credit_err_o           credit count and sticky overflow flag
// master: the router side driving requests; slave: the allocator.
interface output_port_allocator_if #(
    parameter int unsigned NPORTS    = noc_pkg::NPORTS,
    parameter int unsigned BUF_DEPTH = noc_pkg::BUF_DEPTH
);
    localparam int unsigned IW = $clog2(NPORTS);
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

    logic [NPORTS-1:0] req_i;
    logic [NPORTS-1:0] flit_valid_i;
    logic [NPORTS-1:0] flit_tail_i;
    logic              credit_i;
    logic [NPORTS-1:0] grant_o;
    logic [IW-1:0]     sel_o;
    logic [NPORTS-1:0] xfer_o;
    logic              busy_o;
    logic [CW-1:0]     credits_o;
    logic              credit_err_o;

    modport master (
        output req_i, flit_valid_i, flit_tail_i, credit_i,
        input  grant_o, sel_o, xfer_o, busy_o, credits_o, credit_err_o
    );

    modport slave (
        input  req_i, flit_valid_i, flit_tail_i, credit_i,
        output grant_o, sel_o, xfer_o, busy_o, credits_o, credit_err_o
    );

endinterface

// File: rtl/output_port_allocator_rr_pick.sv
// Combinational round-robin pick: first set bit of req searching from ptr
// upward, wrapping N-1 -> 0. No state.
//   req      requests, one bit per input
//   ptr      highest-priority index for this search
//   win      one-hot winner (0 when no request)
//   win_idx  winner index (0 when no request)
//   any      at least one request present
module rr_priority_pick #(
    parameter int unsigned N = noc_pkg::NPORTS,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [IW-1:0] win_idx,
    output logic          any
);

    int unsigned   pos;
    logic [IW-1:0] cand;

    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        pos     = 0;
        cand    = '0;
        // N need not be a power of two, so wrap the index explicitly.
        for (int unsigned off = 0; off < N; off++) begin
            pos = 32'(ptr) + off;
            if (pos >= N) pos = pos - N;
            cand = IW'(pos);
            if (!any && req[cand]) begin
                any     = 1'b1;
                win_idx = cand;
            end
        end
        win[win_idx] = any;
    end

endmodule

// File: rtl/output_port_allocator.sv
// Per-output wormhole allocator: round-robin arbitration of head-flit
// requests, lock to the winner until its tail flit transfers, and gate every
// transfer on a downstream credit counter.
//   clk, rst_n  router clock, asynchronous active-low reset
//   bus         output_port_allocator_if slave modport (requests, flit status,
//               credit return in; grant/sel/xfer/busy/credits/credit_err out)
module output_port_allocator #(
    parameter int unsigned NPORTS    = noc_pkg::NPORTS,
    parameter int unsigned BUF_DEPTH = noc_pkg::BUF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output_port_allocator_if.slave   bus
);
    import noc_pkg::*;

    localparam int unsigned IW   = $clog2(NPORTS);
    localparam int unsigned CW   = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

    alloc_state_e      state;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     owner;
    logic [NPORTS-1:0] grant;
    logic              busy;
    logic [CW-1:0]     credits;
    logic              credit_err;

    logic [NPORTS-1:0] win;
    logic [IW-1:0]     win_idx;
    logic              win_any;
    logic              xfer_any;
    logic              tail_xfer;

    rr_priority_pick #(.N(NPORTS)) u_pick (
        .req     (bus.req_i),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx),
        .any     (win_any)
    );

    // Transfer depends only on registered state, credits and the owner's
    // flit_valid; req_i never reaches xfer_o.
    always_comb begin
        xfer_any  = (state == LOCKED) && bus.flit_valid_i[owner] && (credits != '0);
        tail_xfer = xfer_any && bus.flit_tail_i[owner];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            grant      <= '0;
            busy       <= 1'b0;
            credits    <= FULL;
            credit_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        state <= LOCKED;
                        owner <= win_idx;
                        grant <= win;
                        busy  <= 1'b1;
                        ptr   <= (win_idx == IW'(NPORTS - 1)) ? '0 : win_idx + IW'(1);
                    end
                end
                LOCKED: begin
                    if (tail_xfer) begin
                        state <= IDLE;
                        owner <= '0;
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // A credit arriving with a transfer cancels out; a credit with
            // nothing to absorb it at full count is an overflow.
            if (bus.credit_i && !xfer_any) begin
                if (credits == FULL) credit_err <= 1'b1;
                else                 credits    <= credits + 1'b1;
            end else if (!bus.credit_i && xfer_any) begin
                credits <= credits - 1'b1;
            end
        end
    end

    assign bus.grant_o      = grant;
    assign bus.sel_o        = owner;
    assign bus.xfer_o       = xfer_any ? grant : '0;
    assign bus.busy_o       = busy;
    assign bus.credits_o    = credits;
    assign bus.credit_err_o = credit_err;

endmodule

// File: tb/tb_output_port_allocator.sv
module tb_output_port_allocator;

    localparam int NP  = 5;
    localparam int BD  = 4;

    logic clk = 1'b0;
    logic rst_n;

    output_port_allocator_if #(.NPORTS(NP), .BUF_DEPTH(BD)) bus ();

    output_port_allocator #(.NPORTS(NP), .BUF_DEPTH(BD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: owner (-1 = idle), next search start, credit count, overflow flag.
    int m_owner;
    int m_ptr;
    int m_credits;
    bit m_err;

    // Observations from the latest step.
    int obs_sel;
    bit obs_xfer;
    bit obs_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_owner   = -1;
        m_ptr     = 0;
        m_credits = BD;
        m_err     = 1'b0;
    endtask

    task automatic drive(input logic [NP-1:0] req, input logic [NP-1:0] fv,
                         input logic [NP-1:0] tl, input logic cr);
        bus.req_i        = req;
        bus.flit_valid_i = fv;
        bus.flit_tail_i  = tl;
        bus.credit_i     = cr;
    endtask

    // One clock cycle: drive after the falling edge, compare against the model,
    // then advance the model to what the next rising edge must produce.
    task automatic step(input logic [NP-1:0] req, input logic [NP-1:0] fv,
                        input logic [NP-1:0] tl, input logic cr);
        logic [NP-1:0] eg;
        bit            mx;
        @(negedge clk);
        drive(req, fv, tl, cr);
        #1;
        eg = (m_owner < 0) ? '0 : NP'(1 << m_owner);
        mx = (m_owner >= 0) && fv[m_owner] && (m_credits > 0);
        check("grant",   32'(bus.grant_o), 32'(eg));
        check("sel",     32'(bus.sel_o), (m_owner < 0) ? 0 : m_owner);
        check("busy",    32'(bus.busy_o), 32'(m_owner >= 0));
        check("xfer",    32'(bus.xfer_o), mx ? 32'(eg) : 0);
        check("credits", 32'(bus.credits_o), m_credits);
        check("err",     32'(bus.credit_err_o), 32'(m_err));
        obs_sel  = int'(bus.sel_o);
        obs_xfer = |bus.xfer_o;
        obs_busy = bus.busy_o;

        if (m_owner < 0) begin
            for (int k = 0; k < NP; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % NP]) begin
                    m_owner = (m_ptr + k) % NP;
                    m_ptr   = (m_owner + 1) % NP;
                end
            end
        end else if (mx && tl[m_owner]) begin
            m_owner = -1;
        end
        if (cr && !mx) begin
            if (m_credits == BD) m_err = 1'b1;
            else                 m_credits++;
        end else if (mx && !cr) begin
            m_credits--;
        end
    endtask

    initial begin
        int sel_seq [4];
        int nx;
        logic [NP-1:0] r, v, t;

        sel_seq = '{4, 0, 2, 4};
        rst_n = 1'b0;
        drive('0, '0, '0, 1'b0);
        m_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_grant",   32'(bus.grant_o), 0);
        check("rst_sel",     32'(bus.sel_o), 0);
        check("rst_xfer",    32'(bus.xfer_o), 0);
        check("rst_busy",    32'(bus.busy_o), 0);
        check("rst_credits", 32'(bus.credits_o), BD);
        check("rst_err",     32'(bus.credit_err_o), 0);
        rst_n = 1'b1;

        // Single request from EAST; its tail moves in the granted cycle.
        step(5'b00100, '0, '0, 1'b0);
        step('0, 5'b00100, 5'b00100, 1'b0);
        check("t1_grant_sel", 32'(obs_sel), 2);
        check("t1_xfer", 32'(obs_xfer), 1);

        // Pointer at 3, three ports requesting: grant order 4,0,2,4.
        for (int k = 0; k < 4; k++) begin
            step(5'b10101, '0, '0, 1'b1);
            step(5'b10101, 5'b10101, 5'b10101, 1'b0);
            check("t2_order", 32'(obs_sel), sel_seq[k]);
        end

        // Four-flit packet on NORTH while every other port requests.
        step(5'b11110, '0, '0, 1'b1);
        nx = 0;
        for (int f = 0; f < 4; f++) begin
            step(5'b11111, 5'b00010, (f == 3) ? 5'b00010 : 5'b00000, 1'b0);
            check("t3_owner", 32'(obs_sel), 1);
            nx += int'(obs_xfer);
        end
        check("t3_nxfer", nx, 4);
        repeat (4) step('0, '0, '0, 1'b1);
        step(5'b11111, '0, '0, 1'b0);
        step(5'b11111, 5'b11111, 5'b11111, 1'b0);
        check("t3_single_busy", 32'(obs_busy), 1);
        step('0, '0, '0, 1'b1);
        check("t3_single_release", 32'(obs_busy), 0);

        // Six-flit packet with credit starvation and a recovery pulse.
        step(5'b01000, '0, '0, 1'b0);
        nx = 0;
        for (int c = 0; c < 10; c++) begin
            step('0, 5'b01000, (nx == 5) ? 5'b01000 : 5'b00000,
                 (c == 6 || c == 8 || c == 9) ? 1'b1 : 1'b0);
            nx += int'(obs_xfer);
            if (c == 4 || c == 5) check("t4_stall", 32'(obs_xfer), 0);
            if (c == 3) check("t4_after4", nx, 4);
            if (c == 7) check("t4_one_more", nx, 5);
        end
        check("t4_total", nx, 6);
        step('0, '0, '0, 1'b0);
        check("t4_credit_unchanged", 32'(bus.credits_o), 1);

        // Overflow while idle at full count.
        repeat (3) step('0, '0, '0, 1'b1);
        step('0, '0, '0, 1'b1);
        step('0, '0, '0, 1'b0);
        check("t5_err", 32'(bus.credit_err_o), 1);
        check("t5_full", 32'(bus.credits_o), BD);
        repeat (3) step('0, '0, '0, 1'b0);
        check("t5_sticky", 32'(bus.credit_err_o), 1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            r = NP'($urandom);
            v = NP'($urandom);
            t = NP'($urandom) & NP'($urandom);
            step(r, v, t, ($urandom_range(0, 2) == 0));
        end

        // Reset in the middle of a SOUTH packet with one credit left.
        step('0, '0, '0, 1'b0);
        step('0, '0, '0, 1'b0);
        rst_n = 1'b0;
        #1;
        m_reset();
        rst_n = 1'b1;
        step(5'b01000, '0, '0, 1'b0);
        repeat (3) step('0, 5'b01000, '0, 1'b0);
        @(posedge clk);
        #2;
        check("t6_pre_credits", 32'(bus.credits_o), 1);
        check("t6_pre_owner", 32'(bus.sel_o), 3);
        rst_n = 1'b0;
        #1;
        check("t6_grant", 32'(bus.grant_o), 0);
        check("t6_busy", 32'(bus.busy_o), 0);
        check("t6_xfer", 32'(bus.xfer_o), 0);
        check("t6_credits", 32'(bus.credits_o), BD);
        m_reset();
        drive('0, '0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(5'b11111, '0, '0, 1'b0);
        step('0, '0, '0, 1'b0);
        check("t6_first_grant", 32'(bus.grant_o), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
